wave_play_sched: RTL and testbench
==================================

Name: wave_play_sched

Overview:
- Playback scheduler between the SDRAM controller read port and the AD5791 DAC controller transmit port.
- On start, it sequences SDRAM reads over a circular waveform region and buffers the returned samples in a small FIFO.
- It releases one sample to the DAC per programmable sample period, with flow control on both sides.
- It replaces ad-hoc read pacing so that DAC sample rate is independent of SDRAM latency and refresh stalls.

Parameters:
- DATA_NBIT, 20, DAC sample width (low bits of SDRAM word).
- SDRAM_DATA_NBIT, 32, SDRAM read data width.
- ADDR_NBIT, 24, SDRAM word address width.
- FIFO_DEPTH, 16, sample buffer depth (power of 2, >=4).
- DIV_NBIT, 16, sample-period divider width.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; 1 = play, 0 = stop.
- base_addr  in  ADDR_NBIT  first SDRAM word of waveform; latched on start rise.
- wave_len  in  ADDR_NBIT  samples per period; latched on start rise.
- rate_div  in  DIV_NBIT  sample period = rate_div+1 mclk cycles; sampled at each reload.
- sdram_rd  out  1  single-cycle read request.
- sdram_raddr  out  ADDR_NBIT  read address, valid with sdram_rd.
- sdram_rstatus  in  1  1 = SDRAM controller busy; no sdram_rd while high.
- sdram_rdata  in  SDRAM_DATA_NBIT  read data.
- sdram_rdv  in  1  read data valid, one per request, in order.
- dac_dv  out  1  single-cycle sample strobe.
- dac_data  out  DATA_NBIT  sample, valid with dac_dv, held afterwards.
- dac_waitrequest  in  1  1 = DAC cannot accept.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky: a sample tick found the FIFO empty.
- late  out  1  sticky: a tick arrived while the previous tick was still pending.

Behaviour:
- Reset values:
  - Outputs: sdram_rd=0, sdram_raddr=0, dac_dv=0, dac_data=0, busy=0, underrun=0, late=0.
  - Internal: FIFO empty, outstanding=0, offset=0, divider=0, pending=0, state IDLE.
  - Reset asserted mid-operation aborts immediately. Late sdram_rdv after reset release is ignored because outstanding=0.
- States: IDLE, PREFILL, PLAY, DRAIN.
  - IDLE -> PREFILL: start rising edge with wave_len!=0. Latch base/len, offset=0, clear underrun and late. With wave_len=0, remain IDLE.
  - PREFILL -> PLAY: fifo_count >= FIFO_DEPTH/2. The divider loads rate_div on entry.
  - PREFILL/PLAY -> DRAIN: start=0. Stop issuing reads.
  - DRAIN -> IDLE: outstanding==0. Then flush the FIFO in one cycle. No dac_dv is issued in DRAIN.
  - A start rise during DRAIN is ignored. start must be seen low-to-high again once in IDLE.
- Read issue (PREFILL, PLAY): assert sdram_rd for one cycle when all of these hold:
  - sdram_rstatus=0;
  - sdram_rd was 0 the previous cycle;
  - fifo_count + outstanding < FIFO_DEPTH.
- Read bookkeeping:
  - sdram_raddr = base + offset.
  - offset increments per request and wraps to 0 after wave_len-1.
  - Address arithmetic is modulo 2^ADDR_NBIT.
  - outstanding +1 on sdram_rd, -1 on sdram_rdv; simultaneous = unchanged. sdram_rdv with outstanding=0 is ignored.
- FIFO write: on sdram_rdv with outstanding>0, write sdram_rdata[DATA_NBIT-1:0]. Overflow cannot occur by the issue rule.
- Divider (PLAY only): counts down from rate_div. At 0 it generates a tick and reloads from rate_div.
  - rate_div=0 gives a tick every cycle.
- Tick handling:
  - A tick sets pending.
  - A tick while pending is already set sets late; pending stays 1 and the tick is not queued.
- Sample output: when pending=1, dac_waitrequest=0 and FIFO non-empty, in the same cycle:
  - pop the FIFO;
  - dac_data <= head;
  - dac_dv <= 1 for one cycle (registered, one-cycle latency from the decision);
  - clear pending.
- Underrun: pending=1, dac_waitrequest=0 and FIFO empty -> set underrun, clear pending, no dac_dv; dac_data holds its last value.
- FIFO occupancy: simultaneous FIFO push and pop leave fifo_count unchanged.
- busy = (state != IDLE).

Test Plan:
- Basic play: base=0x100, len=4, rate_div=9, SDRAM read latency 5 -> addresses 100,101,102,103,100,... and dac_dv exactly every 10 cycles in PLAY. Data order matches memory. underrun=0.
- Wrap and back-pressure: len=3, FIFO_DEPTH=16, sdram_rstatus high 20 cycles every 64 -> raddr never exceeds base+2; fifo_count+outstanding <= 16 always; no sdram_rd while rstatus=1.
- Underrun/late: rate_div=0, read latency 8 -> underrun=1 and no dac_dv on empty ticks. Then hold dac_waitrequest high 3 cycles -> late=1. Next start rise clears both.
- Stop mid-play: drop start with 3 reads outstanding -> DRAIN, no new sdram_rd, no dac_dv; IDLE after the 3rd rdv; busy=0; FIFO empty.
- Reset: assert rst_n=0 mid-PLAY with outstanding reads -> all outputs 0 immediately. rdv arriving after reset release is ignored (no FIFO write).
- Edge cases: wave_len=0 with start rise -> stays IDLE, no sdram_rd. Stray sdram_rdv in IDLE -> no effect.

Source files
------------

// File: rtl/wave_play_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wave_play_sched                                            |
// | Description : Waveform playback scheduler. Reads a circular waveform     |
// |               region from SDRAM into a small sample FIFO and releases    |
// |               one sample to the DAC every rate_div+1 clock cycles, so    |
// |               the DAC rate is independent of SDRAM latency and stalls.   |
// | Ports       : mclk/rst_n       clock, async active-low reset             |
// |               start            level, 1 = play, 0 = stop                 |
// |               base_addr/wave_len  waveform region (latched on start)     |
// |               rate_div         sample period - 1 (sampled at reload)     |
// |               sdram_*          read request / read data port             |
// |               dac_*            sample strobe port with waitrequest       |
// |               busy/underrun/late  status (underrun, late are sticky)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wave_play_sched #(
  parameter int DATA_NBIT       = 20,
  parameter int SDRAM_DATA_NBIT = 32,
  parameter int ADDR_NBIT       = 24,
  parameter int FIFO_DEPTH      = 16,
  parameter int DIV_NBIT        = 16
) (
  input  logic                       mclk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_NBIT-1:0]       base_addr,
  input  logic [ADDR_NBIT-1:0]       wave_len,
  input  logic [DIV_NBIT-1:0]        rate_div,
  output logic                       sdram_rd,
  output logic [ADDR_NBIT-1:0]       sdram_raddr,
  input  logic                       sdram_rstatus,
  input  logic [SDRAM_DATA_NBIT-1:0] sdram_rdata,
  input  logic                       sdram_rdv,
  output logic                       dac_dv,
  output logic [DATA_NBIT-1:0]       dac_data,
  input  logic                       dac_waitrequest,
  output logic                       busy,
  output logic                       underrun,
  output logic                       late
);

  localparam int PTR_NBIT = $clog2(FIFO_DEPTH);
  localparam int CNT_NBIT = PTR_NBIT + 1;
  localparam logic [CNT_NBIT-1:0]  CNT_ONE    = CNT_NBIT'(1);
  localparam logic [CNT_NBIT-1:0]  HALF_DEPTH = CNT_NBIT'(FIFO_DEPTH / 2);
  localparam logic [CNT_NBIT:0]    FULL_DEPTH = (CNT_NBIT + 1)'(FIFO_DEPTH);
  localparam logic [PTR_NBIT-1:0]  PTR_ONE    = PTR_NBIT'(1);
  localparam logic [ADDR_NBIT-1:0] ADDR_ONE   = ADDR_NBIT'(1);
  localparam logic [DIV_NBIT-1:0]  DIV_ONE    = DIV_NBIT'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  start_prev_q, start_prev_d;
  logic [ADDR_NBIT-1:0]  base_q, base_d;
  logic [ADDR_NBIT-1:0]  len_q, len_d;
  logic [ADDR_NBIT-1:0]  offset_q, offset_d;
  logic [CNT_NBIT-1:0]   outstanding_q, outstanding_d;
  logic                  rd_prev_q, rd_prev_d;
  logic [PTR_NBIT-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_NBIT-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_NBIT-1:0]   count_q, count_d;
  logic [DIV_NBIT-1:0]   div_q, div_d;
  logic                  pending_q, pending_d;
  logic                  dac_dv_q, dac_dv_d;
  logic [DATA_NBIT-1:0]  dac_data_q, dac_data_d;
  logic                  underrun_q, underrun_d;
  logic                  late_q, late_d;
  logic [DATA_NBIT-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [DATA_NBIT-1:0]  fifo_wdata_d;

  logic start_rise, rd_issue, push, pop, tick, pend_left;

  always_comb begin
    state_d       = state_q;
    start_prev_d  = start;
    base_d        = base_q;
    len_d         = len_q;
    offset_d      = offset_q;
    outstanding_d = outstanding_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    div_d         = div_q;
    pending_d     = pending_q;
    dac_dv_d      = 1'b0;
    dac_data_d    = dac_data_q;
    underrun_d    = underrun_q;
    late_d        = late_q;
    fifo_wdata_d  = sdram_rdata[DATA_NBIT-1:0];
    pop           = 1'b0;
    tick          = 1'b0;
    pend_left     = pending_q;

    start_rise = start & ~start_prev_q;

    // One request at most every other cycle; the occupancy bound counts
    // in-flight reads so a returning word always has a FIFO slot.
    rd_issue = ((state_q == ST_PREFILL) || (state_q == ST_PLAY)) &&
               !sdram_rstatus && !rd_prev_q &&
               (({1'b0, count_q} + {1'b0, outstanding_q}) < FULL_DEPTH);
    rd_prev_d = rd_issue;

    // Data with nothing outstanding is stale (e.g. left over from before
    // a reset) and is dropped.
    push = sdram_rdv && (outstanding_q != '0);

    if (rd_issue && !push) begin
      outstanding_d = outstanding_q + CNT_ONE;
    end else if (!rd_issue && push) begin
      outstanding_d = outstanding_q - CNT_ONE;
    end

    if (rd_issue) begin
      offset_d = (offset_q == len_q - ADDR_ONE) ? '0 : offset_q + ADDR_ONE;
    end

    if (state_q == ST_PLAY) begin
      if (div_q == '0) begin
        tick  = 1'b1;
        div_d = rate_div;
      end else begin
        div_d = div_q - DIV_ONE;
      end

      if (pending_q && !dac_waitrequest) begin
        if (count_q != '0) begin
          pop        = 1'b1;
          dac_dv_d   = 1'b1;
          dac_data_d = fifo_mem_q[rd_ptr_q];
        end else begin
          underrun_d = 1'b1;
        end
        pend_left = 1'b0;
      end

      // Late only when the earlier tick is still unserved after this
      // cycle's service decision; a tick is never queued behind another.
      if (tick) begin
        if (pend_left) begin
          late_d = 1'b1;
        end
        pending_d = 1'b1;
      end else begin
        pending_d = pend_left;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise && (wave_len != '0)) begin
          state_d    = ST_PREFILL;
          base_d     = base_addr;
          len_d      = wave_len;
          offset_d   = '0;
          underrun_d = 1'b0;
          late_d     = 1'b0;
        end
      end
      ST_PREFILL: begin
        if (!start) begin
          state_d = ST_DRAIN;
        end else if (count_q >= HALF_DEPTH) begin
          state_d = ST_PLAY;
          div_d   = rate_div;
        end
      end
      ST_PLAY: begin
        if (!start) begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        // Wait for every in-flight read to land, then discard the buffer.
        if (outstanding_q == '0) begin
          state_d   = ST_IDLE;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          pending_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      start_prev_q  <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      offset_q      <= '0;
      outstanding_q <= '0;
      rd_prev_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      div_q         <= '0;
      pending_q     <= 1'b0;
      dac_dv_q      <= 1'b0;
      dac_data_q    <= '0;
      underrun_q    <= 1'b0;
      late_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_prev_d;
      base_q        <= base_d;
      len_q         <= len_d;
      offset_q      <= offset_d;
      outstanding_q <= outstanding_d;
      rd_prev_q     <= rd_prev_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      div_q         <= div_d;
      pending_q     <= pending_d;
      dac_dv_q      <= dac_dv_d;
      dac_data_q    <= dac_data_d;
      underrun_q    <= underrun_d;
      late_q        <= late_d;
    end
  end

  // Sample storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge mclk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= fifo_wdata_d;
    end
  end

  generate
    if (SDRAM_DATA_NBIT > DATA_NBIT) begin : g_unused_rdata
      logic unused_rdata_bits;
      assign unused_rdata_bits = ^sdram_rdata[SDRAM_DATA_NBIT-1:DATA_NBIT];
    end
  endgenerate

  assign sdram_rd    = rd_issue;
  assign sdram_raddr = base_q + offset_q;
  assign dac_dv      = dac_dv_q;
  assign dac_data    = dac_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign underrun    = underrun_q;
  assign late        = late_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_play_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wave_play_sched                                         |
// | Description : Scoreboard bench for wave_play_sched with an SDRAM read    |
// |               model of programmable latency and busy pattern.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wave_play_sched;

  localparam int DATA_NBIT = 20;
  localparam int SDW       = 32;
  localparam int AW        = 24;
  localparam int DEPTH     = 16;
  localparam int DW        = 16;

  logic                 mclk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [AW-1:0]        wave_len = '0;
  logic [DW-1:0]        rate_div = '0;
  logic                 sdram_rstatus = 1'b0;
  logic [SDW-1:0]       sdram_rdata = '0;
  logic                 sdram_rdv = 1'b0;
  logic                 dac_waitrequest = 1'b0;
  logic                 sdram_rd;
  logic [AW-1:0]        sdram_raddr;
  logic                 dac_dv;
  logic [DATA_NBIT-1:0] dac_data;
  logic                 busy, underrun, late;

  always #5 mclk = ~mclk;

  wave_play_sched #(
    .DATA_NBIT(DATA_NBIT), .SDRAM_DATA_NBIT(SDW), .ADDR_NBIT(AW),
    .FIFO_DEPTH(DEPTH), .DIV_NBIT(DW)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .wave_len(wave_len), .rate_div(rate_div),
    .sdram_rd(sdram_rd), .sdram_raddr(sdram_raddr),
    .sdram_rstatus(sdram_rstatus), .sdram_rdata(sdram_rdata), .sdram_rdv(sdram_rdv),
    .dac_dv(dac_dv), .dac_data(dac_data), .dac_waitrequest(dac_waitrequest),
    .busy(busy), .underrun(underrun), .late(late)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // SDRAM model controls and request log
  int            lat = 5;
  bit            rs_en = 1'b0;
  bit            rs_force = 1'b0;
  int            inject_req = 0;
  int            inject_done = 0;
  logic [AW-1:0] req_addr[$];
  int            req_due[$];
  int            rd_idx = 0;
  int            rdv_cnt = 0;

  // Scoreboards
  logic [AW-1:0]        exp_addr[$];
  logic [DATA_NBIT-1:0] exp_smp[$];
  int rd_cnt = 0, dv_cnt = 0, last_dv = -1, per = 0;
  bit per_chk = 1'b0, occ_en = 1'b0;
  int rdv_base = 0, dv_base = 0, rs_viol = 0, occ_viol = 0;

  // Memory contents: low 20 bits carry the sample, upper bits are filler
  // that the DUT must strip.
  function automatic logic [DATA_NBIT-1:0] exp_sample(input logic [AW-1:0] a);
    return a[19:0] * 20'd3 + 20'd7;
  endfunction

  function automatic logic [SDW-1:0] mem_word(input logic [AW-1:0] a);
    return {12'hA5A, exp_sample(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge mclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, bound);
    end
  endtask

  task automatic start_play(input logic [AW-1:0] b, input logic [AW-1:0] l,
                            input logic [DW-1:0] rdiv, input int latency, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i % int'(l));
      exp_addr.push_back(a);
      exp_smp.push_back(exp_sample(a));
    end
    lat       = latency;
    last_dv   = -1;
    base_addr = b;
    wave_len  = l;
    rate_div  = rdiv;
    start     = 1'b1;
  endtask

  task automatic stop_play(input string name);
    start = 1'b0;
    wait_idle(name, 200);
    per_chk = 1'b0;
    exp_addr.delete();
    exp_smp.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sdram_rd"}, 32'(sdram_rd), 0);
    check({tag, "_sdram_raddr"}, 32'(sdram_raddr), 0);
    check({tag, "_dac_dv"}, 32'(dac_dv), 0);
    check({tag, "_dac_data"}, 32'(dac_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_underrun"}, 32'(underrun), 0);
    check({tag, "_late"}, 32'(late), 0);
  endtask

  // SDRAM model: returns requests in order after lat cycles, one per cycle.
  initial begin
    forever begin
      @(posedge mclk);
      cyc++;
      #1;
      sdram_rdv = 1'b0;
      if (inject_req != inject_done) begin
        sdram_rdv   = 1'b1;
        sdram_rdata = 32'hDEAD_BEEF;
        inject_done++;
      end else if (rd_idx < req_addr.size() && req_due[rd_idx] <= cyc) begin
        sdram_rdv   = 1'b1;
        sdram_rdata = mem_word(req_addr[rd_idx]);
        rd_idx++;
        rdv_cnt++;
      end
      sdram_rstatus = rs_force || (rs_en && ((cyc % 64) < 20));
    end
  end

  // Monitor: compares every DAC strobe and every read request against the
  // scoreboard queues.
  initial begin
    forever begin
      @(negedge mclk);
      if (dac_dv) begin
        dv_cnt++;
        if (exp_smp.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL dac_dv_unexpected: got strobe with data 0x%0h, required none", dac_data);
        end else begin
          check("dac_data", 32'(dac_data), 32'(exp_smp.pop_front()));
        end
        if (per_chk && last_dv >= 0) check("dv_period", 32'(cyc - last_dv), 32'(per));
        last_dv = cyc;
      end
      if (occ_en &&
          ((req_addr.size() - rd_idx) + (rdv_cnt - rdv_base) - (dv_cnt - dv_base)) > DEPTH)
        occ_viol++;
      if (sdram_rd) begin
        rd_cnt++;
        if (sdram_rstatus) rs_viol++;
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sdram_rd_unexpected: got read of 0x%0h, required none", sdram_raddr);
        end else begin
          check("sdram_raddr", 32'(sdram_raddr), 32'(exp_addr.pop_front()));
        end
        req_addr.push_back(sdram_raddr);
        req_due.push_back(cyc + lat);
      end
    end
  end

  initial begin
    int rd_b, dv_b, dv0;
    bit found;

    // Reset values
    #12;
    check_outputs_zero("reset");
    step(2);
    rst_n = 1'b1;
    step(2);

    // wave_len = 0 never leaves IDLE; a stray rdv in IDLE is dropped
    base_addr = 24'h55;
    wave_len  = '0;
    start     = 1'b1;
    step(10);
    check("len0_busy", 32'(busy), 0);
    check("len0_rd_count", 32'(rd_cnt), 0);
    start = 1'b0;
    step(2);
    inject_req++;
    step(5);
    check("stray_busy", 32'(busy), 0);
    check("stray_dv_count", 32'(dv_cnt), 0);

    // Basic play: 0x100..0x103 wrapping, one sample every 10 cycles
    dv0 = dv_cnt;
    per = 10;
    per_chk = 1'b1;
    start_play(24'h100, 24'd4, 16'd9, 5, 120);
    step(300);
    check("basic_underrun", 32'(underrun), 0);
    check("basic_late", 32'(late), 0);
    check("basic_dv_count_ge20", 32'((dv_cnt - dv0) >= 20), 1);
    stop_play("basic_stop");

    // Wrap with SDRAM busy 20 of every 64 cycles
    rdv_base = rdv_cnt;
    dv_base  = dv_cnt;
    rs_viol  = 0;
    occ_viol = 0;
    occ_en   = 1'b1;
    rs_en    = 1'b1;
    dv0      = dv_cnt;
    start_play(24'h300, 24'd3, 16'd4, 5, 300);
    step(400);
    occ_en = 1'b0;
    rs_en  = 1'b0;
    check("wrap_rd_while_busy", 32'(rs_viol), 0);
    check("wrap_occupancy_over", 32'(occ_viol), 0);
    check("wrap_underrun", 32'(underrun), 0);
    check("wrap_dv_count_ge40", 32'((dv_cnt - dv0) >= 40), 1);
    stop_play("wrap_stop");

    // Underrun with rate_div=0, then late via waitrequest
    start_play(24'h20, 24'd6, 16'd0, 8, 200);
    step(100);
    check("underrun_set", 32'(underrun), 1);
    dac_waitrequest = 1'b1;
    step(3);
    dac_waitrequest = 1'b0;
    step(2);
    check("late_set", 32'(late), 1);
    stop_play("late_stop");
    start_play(24'h20, 24'd6, 16'd0, 8, 50);
    step(2);
    check("restart_busy", 32'(busy), 1);
    check("restart_underrun_clr", 32'(underrun), 0);
    check("restart_late_clr", 32'(late), 0);
    stop_play("restart_stop");

    // Stop with three reads outstanding
    start_play(24'h40, 24'd7, 16'd0, 12, 150);
    step(40);
    rs_force = 1'b1;
    step(2);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge mclk);
      if ((req_addr.size() - rd_idx) == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("stop_reached_3_outstanding", 32'(found), 1);
    check("stop_busy_before", 32'(busy), 1);
    start    = 1'b0;
    rs_force = 1'b0;
    rd_b     = rd_cnt;
    repeat (2) @(posedge mclk);
    #3;
    dv_b = dv_cnt;
    wait_idle("drain_idle", 60);
    check("drain_outstanding_at_idle", 32'(req_addr.size() - rd_idx), 0);
    check("drain_no_rd", 32'(rd_cnt), 32'(rd_b));
    check("drain_no_dv", 32'(dv_cnt), 32'(dv_b));
    per_chk = 1'b0;
    exp_addr.delete();
    exp_smp.delete();

    // Asynchronous reset mid-play with reads in flight
    start_play(24'h200, 24'd5, 16'd3, 10, 150);
    step(40);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge mclk);
      if ((req_addr.size() - rd_idx) > 0) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reads_in_flight", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    start = 1'b0;
    exp_addr.delete();
    exp_smp.delete();
    step(2);
    rst_n = 1'b1;
    step(25);
    check("post_rst_busy", 32'(busy), 0);
    // First sample after restart proves the late rdvs were not buffered.
    start_play(24'h200, 24'd5, 16'd3, 10, 100);
    step(80);
    check("post_rst_underrun", 32'(underrun), 0);
    stop_play("post_rst_stop");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
